// File: rtl/i2c_slave_read_byte.sv
// i2c_slave_read_byte: receives one DATA_WIDTH-bit byte, MSB first, by
// launching an external bit-reader once per SCL rise, then optionally
// drives the ACK slot (SDA low for the 9th SCL clock) before reporting.
module i2c_slave_read_byte #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  ack_en,
   input  logic                  scl,
   output logic                  bit_enable,
   input  logic                  bit_data,
   input  logic                  bit_error,
   input  logic                  bit_finish,
   output logic                  sda_oe,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  finish,
   output logic                  error,
   output logic                  busy
);

   localparam int            CW   = $clog2(DATA_WIDTH) + 1;
   localparam logic [CW-1:0] BITS = CW'(DATA_WIDTH);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_RISE = 3'd1,
      WAIT_BIT  = 3'd2,
      ACK_FALL  = 3'd3,
      ACK_HOLD  = 3'd4,
      ACK_REL   = 3'd5
   } state_t;

   state_t                state_r;
   logic                  scl_last_r;
   logic [DATA_WIDTH-1:0] shift_r;
   logic [CW-1:0]         count_r;

   logic                  rise_s;
   logic                  fall_s;
   logic [DATA_WIDTH:0]   shift_ext_s;
   logic [DATA_WIDTH-1:0] shift_next_s;
   logic [CW-1:0]         count_next_s;
   logic                  more_bits_s;

   // SCL edge detection and the shift/count values after accepting one bit
   always_comb begin
      rise_s       = ~scl_last_r & scl;
      fall_s       = scl_last_r & ~scl;
      shift_ext_s  = {shift_r, bit_data};
      shift_next_s = shift_ext_s[DATA_WIDTH-1:0];
      count_next_s = count_r + ONE;
      more_bits_s  = (count_next_s < BITS);
   end

   // Transfer sequencer: state, shift register, bit count, SCL history and all outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         scl_last_r <= 1'b1;
         shift_r    <= {DATA_WIDTH{1'b0}};
         count_r    <= {CW{1'b0}};
         data       <= {DATA_WIDTH{1'b0}};
         bit_enable <= 1'b0;
         sda_oe     <= 1'b0;
         finish     <= 1'b0;
         error      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         scl_last_r <= scl;
         bit_enable <= 1'b0;
         finish     <= 1'b0;
         error      <= 1'b0;
         case (state_r)
            IDLE: begin
               sda_oe <= 1'b0;
               if (start) begin
                  shift_r <= {DATA_WIDTH{1'b0}};
                  count_r <= {CW{1'b0}};
                  busy    <= 1'b1;
                  state_r <= WAIT_RISE;
               end else begin
                  busy    <= 1'b0;
               end
            end
            WAIT_RISE: begin
               if (rise_s) begin
                  bit_enable <= 1'b1;
                  state_r    <= WAIT_BIT;
               end
            end
            WAIT_BIT: begin
               if (bit_finish) begin
                  if (bit_error) begin
                     // Abort: the previously delivered byte stays visible on data
                     error   <= 1'b1;
                     busy    <= 1'b0;
                     state_r <= IDLE;
                  end else begin
                     shift_r <= shift_next_s;
                     count_r <= count_next_s;
                     if (more_bits_s) begin
                        state_r <= WAIT_RISE;
                     end else begin
                        data <= shift_next_s;
                        // ack_en is looked at only here, when the last bit lands
                        if (ack_en) begin
                           state_r <= ACK_FALL;
                        end else begin
                           finish  <= 1'b1;
                           busy    <= 1'b0;
                           state_r <= IDLE;
                        end
                     end
                  end
               end
            end
            ACK_FALL: begin
               if (fall_s) begin
                  sda_oe  <= 1'b1;
                  state_r <= ACK_HOLD;
               end
            end
            ACK_HOLD: begin
               sda_oe <= 1'b1;
               if (rise_s) begin
                  state_r <= ACK_REL;
               end
            end
            ACK_REL: begin
               if (fall_s) begin
                  sda_oe  <= 1'b0;
                  finish  <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            default: begin
               sda_oe  <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave_read_byte.sv
// tb_i2c_slave_read_byte: drives SCL and plays the bit-reader; expected bytes
// go into a queue and are matched against data whenever finish pulses.
module tb_i2c_slave_read_byte;

   localparam int  W      = 8;
   localparam time PERIOD = 10;

   logic         clock      = 1'b0;
   logic         reset      = 1'b1;
   logic         start      = 1'b0;
   logic         ack_en     = 1'b0;
   logic         scl        = 1'b0;
   logic         bit_data   = 1'b0;
   logic         bit_error  = 1'b0;
   logic         bit_finish = 1'b0;
   logic         bit_enable;
   logic         sda_oe;
   logic         finish;
   logic         error;
   logic         busy;
   logic [W-1:0] data;

   int           checks      = 0;
   int           failures    = 0;
   int           be_cnt      = 0;
   int           fin_cnt     = 0;
   int           err_cnt     = 0;
   int           sda_on_cnt  = 0;
   int           sda_off_cnt = 0;
   time          rise_time   = 0;
   time          fall_time   = 0;
   logic         sda_prev    = 1'b0;
   logic [W-1:0] mon_exp;
   logic [W-1:0] exp_q[$];

   always #5 clock = ~clock;

   i2c_slave_read_byte #(.DATA_WIDTH(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .ack_en     (ack_en),
      .scl        (scl),
      .bit_enable (bit_enable),
      .bit_data   (bit_data),
      .bit_error  (bit_error),
      .bit_finish (bit_finish),
      .sda_oe     (sda_oe),
      .data       (data),
      .finish     (finish),
      .error      (error),
      .busy       (busy)
   );

   // Output monitor and scoreboard, sampled on the falling clock edge
   always @(negedge clock) begin
      checks++;
      if (finish === 1'b1 && error === 1'b1) begin
         failures++;
         $display("FAIL finish_error_overlap: finish=%b error=%b, required not both 1", finish, error);
      end
      if (bit_enable === 1'b1) begin
         be_cnt++;
         checks++;
         if (($time - rise_time) != PERIOD) begin
            failures++;
            $display("FAIL bit_enable_latency: %0t after SCL rise, required %0t", $time - rise_time, PERIOD);
         end
      end
      if (error === 1'b1) err_cnt++;
      if (finish === 1'b1) begin
         fin_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_finish: data=%h with no byte expected", data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (data !== mon_exp) begin
               failures++;
               $display("FAIL finish_data: got %h, required %h", data, mon_exp);
            end
         end
      end
      if (reset === 1'b0 && sda_oe !== sda_prev) begin
         if (sda_oe === 1'b1) sda_on_cnt++;
         else sda_off_cnt++;
         checks++;
         if (($time - fall_time) != PERIOD) begin
            failures++;
            $display("FAIL sda_oe_edge: changed %0t after SCL fall, required %0t", $time - fall_time, PERIOD);
         end
      end
      sda_prev = sda_oe;
   end

   task automatic clear_counts();
      be_cnt = 0; fin_cnt = 0; err_cnt = 0; sda_on_cnt = 0; sda_off_cnt = 0;
   endtask

   // One SCL high phase with the bit-reader answering while SCL is high
   task automatic drive_bit(input logic b, input logic e, input logic poke);
      @(negedge clock);
      scl = 1'b1; rise_time = $time;
      @(negedge clock);
      start = poke;
      @(negedge clock);
      start = 1'b0;
      bit_data = b; bit_error = e; bit_finish = 1'b1;
      @(negedge clock);
      bit_finish = 1'b0; bit_error = 1'b0; bit_data = 1'b0;
      scl = 1'b0; fall_time = $time;
      @(negedge clock);
   endtask

   // Ninth SCL clock carrying the ACK
   task automatic ack_clock();
      @(negedge clock);
      scl = 1'b1; rise_time = $time;
      repeat (3) @(negedge clock);
      scl = 1'b0; fall_time = $time;
      repeat (2) @(negedge clock);
   endtask

   // Start pulse then bits MSB first; stops after the bit flagged as error
   task automatic send_byte(input logic [W-1:0] b, input int err_bit, input int poke_bit);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < W; i++) begin
         drive_bit(b[W-1-i], (i == err_bit), (i == poke_bit));
         if (i == err_bit) break;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      checks += 6;
      if (sda_oe !== 1'b0)     begin failures++; $display("FAIL reset_sda_oe: got %b, required 0", sda_oe); end
      if (bit_enable !== 1'b0) begin failures++; $display("FAIL reset_bit_enable: got %b, required 0", bit_enable); end
      if (finish !== 1'b0)     begin failures++; $display("FAIL reset_finish: got %b, required 0", finish); end
      if (error !== 1'b0)      begin failures++; $display("FAIL reset_error: got %b, required 0", error); end
      if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
      if (data !== 8'h00)      begin failures++; $display("FAIL reset_data: got %h, required 00", data); end
      reset = 1'b0;
      clear_counts();
      @(negedge clock);
      scl = 1'b1; rise_time = $time;
      repeat (3) @(negedge clock);
      scl = 1'b0; fall_time = $time;
      repeat (2) @(negedge clock);
      checks += 2;
      if (be_cnt != 0)    begin failures++; $display("FAIL idle_rise_launch: bit_enable pulses %0d, required 0", be_cnt); end
      if (busy !== 1'b0)  begin failures++; $display("FAIL idle_busy: got %b, required 0", busy); end
   endtask

   task automatic test_no_ack();
      ack_en = 1'b0;
      clear_counts();
      exp_q.push_back(8'hA5);
      send_byte(8'hA5, -1, -1);
      repeat (2) @(negedge clock);
      checks += 6;
      if (be_cnt != 8)       begin failures++; $display("FAIL a5_bit_enable_count: got %0d, required 8", be_cnt); end
      if (fin_cnt != 1)      begin failures++; $display("FAIL a5_finish_count: got %0d, required 1", fin_cnt); end
      if (err_cnt != 0)      begin failures++; $display("FAIL a5_error_count: got %0d, required 0", err_cnt); end
      if (sda_on_cnt != 0)   begin failures++; $display("FAIL a5_sda_oe: asserted %0d times, required 0", sda_on_cnt); end
      if (data !== 8'hA5)    begin failures++; $display("FAIL a5_data: got %h, required a5", data); end
      if (busy !== 1'b0)     begin failures++; $display("FAIL a5_busy: got %b, required 0", busy); end
   endtask

   task automatic test_ack();
      ack_en = 1'b1;
      clear_counts();
      exp_q.push_back(8'h3C);
      send_byte(8'h3C, -1, -1);
      checks += 3;
      if (sda_oe !== 1'b1)   begin failures++; $display("FAIL 3c_ack_drive: sda_oe=%b, required 1", sda_oe); end
      if (fin_cnt != 0)      begin failures++; $display("FAIL 3c_early_finish: got %0d, required 0", fin_cnt); end
      if (busy !== 1'b1)     begin failures++; $display("FAIL 3c_ack_busy: got %b, required 1", busy); end
      ack_clock();
      checks += 6;
      if (fin_cnt != 1)      begin failures++; $display("FAIL 3c_finish_count: got %0d, required 1", fin_cnt); end
      if (sda_on_cnt != 1)   begin failures++; $display("FAIL 3c_sda_on: got %0d, required 1", sda_on_cnt); end
      if (sda_off_cnt != 1)  begin failures++; $display("FAIL 3c_sda_off: got %0d, required 1", sda_off_cnt); end
      if (be_cnt != 8)       begin failures++; $display("FAIL 3c_bit_enable_count: got %0d, required 8", be_cnt); end
      if (data !== 8'h3C)    begin failures++; $display("FAIL 3c_data: got %h, required 3c", data); end
      if (sda_oe !== 1'b0)   begin failures++; $display("FAIL 3c_sda_release: got %b, required 0", sda_oe); end
      ack_en = 1'b0;
   endtask

   task automatic test_bit_error();
      ack_en = 1'b0;
      exp_q.push_back(8'h13);
      send_byte(8'h13, -1, -1);
      repeat (2) @(negedge clock);
      clear_counts();
      send_byte(8'hE6, 2, -1);
      checks += 5;
      if (err_cnt != 1)      begin failures++; $display("FAIL err_error_count: got %0d, required 1", err_cnt); end
      if (fin_cnt != 0)      begin failures++; $display("FAIL err_finish_count: got %0d, required 0", fin_cnt); end
      if (data !== 8'h13)    begin failures++; $display("FAIL err_data_kept: got %h, required 13", data); end
      if (busy !== 1'b0)     begin failures++; $display("FAIL err_busy: got %b, required 0", busy); end
      if (be_cnt != 3)       begin failures++; $display("FAIL err_bit_enable_count: got %0d, required 3", be_cnt); end
      repeat (2) @(negedge clock);
   endtask

   task automatic test_start_ignored();
      ack_en = 1'b0;
      clear_counts();
      exp_q.push_back(8'h9B);
      send_byte(8'h9B, -1, 3);
      repeat (2) @(negedge clock);
      checks += 4;
      if (be_cnt != 8)       begin failures++; $display("FAIL restart_bit_enable_count: got %0d, required 8", be_cnt); end
      if (fin_cnt != 1)      begin failures++; $display("FAIL restart_finish_count: got %0d, required 1", fin_cnt); end
      if (err_cnt != 0)      begin failures++; $display("FAIL restart_error_count: got %0d, required 0", err_cnt); end
      if (data !== 8'h9B)    begin failures++; $display("FAIL restart_data: got %h, required 9b", data); end
   endtask

   task automatic test_reset_in_ack();
      ack_en = 1'b1;
      clear_counts();
      send_byte(8'h6E, -1, -1);
      checks++;
      if (sda_oe !== 1'b1)   begin failures++; $display("FAIL rst_ack_pre: sda_oe=%b, required 1", sda_oe); end
      #2;
      reset = 1'b1;
      #1;
      checks += 2;
      if (sda_oe !== 1'b0)   begin failures++; $display("FAIL rst_ack_sda_oe: got %b, required 0", sda_oe); end
      if (busy !== 1'b0)     begin failures++; $display("FAIL rst_ack_busy: got %b, required 0", busy); end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      ack_en = 1'b0;
      @(negedge clock);
      checks++;
      if (fin_cnt != 0)      begin failures++; $display("FAIL rst_ack_finish: got %0d, required 0", fin_cnt); end
      clear_counts();
      exp_q.push_back(8'hDF);
      send_byte(8'hDF, -1, -1);
      repeat (2) @(negedge clock);
      checks += 2;
      if (data !== 8'hDF)    begin failures++; $display("FAIL rst_after_data: got %h, required df", data); end
      if (fin_cnt != 1)      begin failures++; $display("FAIL rst_after_finish: got %0d, required 1", fin_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] bytes [4];
      bytes[0] = 8'h13; bytes[1] = 8'h57; bytes[2] = 8'h9B; bytes[3] = 8'hDF;
      ack_en = 1'b0;
      clear_counts();
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(bytes[k]);
         send_byte(bytes[k], -1, -1);
      end
      repeat (2) @(negedge clock);
      checks += 5;
      if (fin_cnt != 4)      begin failures++; $display("FAIL b2b_finish_count: got %0d, required 4", fin_cnt); end
      if (err_cnt != 0)      begin failures++; $display("FAIL b2b_error_count: got %0d, required 0", err_cnt); end
      if (be_cnt != 32)      begin failures++; $display("FAIL b2b_bit_enable_count: got %0d, required 32", be_cnt); end
      if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_pending: %0d bytes never finished, required 0", exp_q.size()); end
      if (data !== 8'hDF)    begin failures++; $display("FAIL b2b_last_data: got %h, required df", data); end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_no_ack();
      test_ack();
      test_bit_error();
      test_start_ignored();
      test_reset_in_ack();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Run-time bound
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
